// File: rtl/jtframe_joyser_pkg.sv
// Shared FSM encoding and frame-length helper for the DB9 joystick serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtframe_joyser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int frame_len(input int joy_w);
        return 2 * joy_w;
    endfunction

endpackage

// File: rtl/jtframe_sync_edge.sv
// 2-FF synchroniser for an asynchronous pin plus a rising-edge strobe.
// Latency: level and rise strobe valid 2 clk_sys cycles after the pin changes.
// Backpressure: none; the pin is sampled every cycle.
module jtframe_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the pin's idle level so no spurious edge appears after reset.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign lvl_o  = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/jtframe_joy_serializer.sv
// 74HC165-style target for the DB9 joystick link; optional watchdog via JTFRAME_JOYSER_TIMEOUT_EN.
// Latency: 3 clk_sys cycles from JOY_LOAD/JOY_CLK pin to JOY_DATA.
// Backpressure: none; the reader paces the frame through JOY_CLK.
module jtframe_joy_serializer
    import jtframe_joyser_pkg::*;
#(
    parameter int JOY_W      = 12,
    parameter bit ACTIVE_LOW = 1'b1
`ifdef JTFRAME_JOYSER_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 4096
`endif
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic [JOY_W-1:0] joystick1,
    input  logic [JOY_W-1:0] joystick2,
    input  logic             JOY_LOAD,
    input  logic             JOY_CLK,
    output logic             JOY_DATA,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err
);

    localparam int LEN = frame_len(JOY_W);
    localparam int CW  = $clog2(LEN + 1);

    logic ld_lvl, ld_rise, ck_lvl, ck_rise;

    jtframe_sync_edge #(.RST_VAL(1'b1)) u_sync_load (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .d_i     (JOY_LOAD),
        .lvl_o   (ld_lvl),
        .rise_o  (ld_rise)
    );

    jtframe_sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .d_i     (JOY_CLK),
        .lvl_o   (ck_lvl),
        .rise_o  (ck_rise)
    );

    // Shadow holds wire levels, so shifting in 1 leaves the line idle-high past the frame.
    logic [LEN-1:0] frame_wire;
    assign frame_wire = {joystick1, joystick2} ^ {LEN{ACTIVE_LOW}};

    state_t         state_q, state_d;
    logic [LEN-1:0] shadow_q, shadow_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           data_q, data_d;
    logic           done_q, done_d;
`ifdef JTFRAME_JOYSER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0]  wd_q, wd_d;
    logic           to_q, to_d;
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
`ifdef JTFRAME_JOYSER_TIMEOUT_EN
        wd_d     = '0;
        to_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                shadow_d = frame_wire;
                cnt_d    = '0;
                if (ld_rise) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ck_rise) begin
                    shadow_d = {shadow_q[LEN-2:0], 1'b1};
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_d == CW'(LEN)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
`ifdef JTFRAME_JOYSER_TIMEOUT_EN
                else begin
                    wd_d = wd_q + WW'(1);
                    if (wd_d == WW'(TIMEOUT)) begin
                        state_d = ST_IDLE;
                        to_d    = 1'b1;
                    end
                end
`endif
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        // Load has priority over everything, including a coincident clock edge.
        if (!ld_lvl) begin
            state_d  = ST_LOAD;
            shadow_d = frame_wire;
            cnt_d    = '0;
            done_d   = 1'b0;
`ifdef JTFRAME_JOYSER_TIMEOUT_EN
            wd_d     = '0;
            to_d     = 1'b0;
`endif
        end

        data_d = 1'b1;
        if (state_d == ST_LOAD || state_d == ST_SHIFT) data_d = shadow_d[LEN-1];
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            data_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef JTFRAME_JOYSER_TIMEOUT_EN
            wd_q     <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            done_q   <= done_d;
`ifdef JTFRAME_JOYSER_TIMEOUT_EN
            wd_q     <= wd_d;
            to_q     <= to_d;
`endif
        end
    end

    assign JOY_DATA   = data_q;
    assign busy       = (state_q == ST_SHIFT);
    assign frame_done = done_q;
`ifdef JTFRAME_JOYSER_TIMEOUT_EN
    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Synced JOY_CLK level is only needed for its edge.
    logic unused_ck_lvl;
    assign unused_ck_lvl = ck_lvl;

endmodule
